cpu_issue_arbiter: RTL

- Shares the single-cycle 8-bit CPU core (register file, ALU and data_out/status path) between NUM_REQ instruction requesters.
- Each requester submits 16-bit instruction words over a valid/ready handshake. The block arbitrates round-robin and drives the core's instruction bytes.
- It returns the core's data output to the issuing requester for STB/RDS instructions.
- An optional lock keeps the core dedicated to one requester across a multi-instruction sequence, so carry status is not corrupted by interleaving.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/cpu_issue_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU issue path: opcodes, NOP word and arbiter FSM states.
package cpu_pkg;

    localparam logic [3:0] OP_MVR   = 4'b0000;
    localparam logic [3:0] OP_LDB   = 4'b0001;
    localparam logic [3:0] OP_STB   = 4'b0010;
    localparam logic [3:0] OP_RDS   = 4'b0011;
    localparam logic [3:0] OP_NOP   = 4'b0100;
    localparam logic [7:0] NOP_WORD = {OP_NOP, 4'b0000};

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;

    // STB and RDS put a result on the core's data output.
    function automatic logic is_rsp_op(input logic [3:0] op);
        return (op == OP_STB) || (op == OP_RDS);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request above ptr.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (enable && !found && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_issue_arbiter.sv
// Shares one single-cycle CPU core between NUM_REQ requesters with round-robin
// issue, optional multi-beat lock with idle timeout, and STB/RDS response return.
module cpu_issue_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned LOCK_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_inst,
    input  logic [NUM_REQ-1:0]      req_lock,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [7:0]              core_ui,
    output logic [7:0]              core_uio,
    input  logic [7:0]              core_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    lock_err
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] grant, ready;
    logic [PW-1:0]      gidx;
    logic [15:0]        word;
    logic               issue, arb_en;

    assign arb_en = rst_n && (state_q == ST_IDLE);

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req    (req_valid),
        .ptr    (rr_q),
        .enable (arb_en),
        .grant  (grant)
    );

    always_comb begin
        ready = '0;
        gidx  = owner_q;
        if (rst_n) begin
            if (state_q == ST_LOCKED) begin
                ready[owner_q] = 1'b1;
            end else begin
                ready = grant;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) gidx = PW'(i);
                end
            end
        end
    end

    assign issue     = |(req_valid & ready);
    assign word      = req_inst[{gidx, 4'b0000} +: 16];
    assign req_ready = ready;
    assign core_ui   = issue ? word[15:8] : NOP_WORD;
    assign core_uio  = issue ? word[7:0]  : 8'h00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = (|rsp_valid_q) ? core_data : 8'h00;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        lock_err    = 1'b0;
        rsp_valid_d = '0;
        if (issue && is_rsp_op(word[15:12])) rsp_valid_d = ready;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    rr_d = gidx;
                    if (req_lock[gidx]) begin
                        state_d = ST_LOCKED;
                        owner_d = gidx;
                        cnt_d   = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (issue) begin
                    cnt_d = '0;
                    if (!req_lock[owner_q]) state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(LOCK_MAX)) begin
                    // Forced release: this cycle issues a NOP, the next one re-arbitrates.
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    lock_err = rst_n;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= PW'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule
